// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Shares one external combinational single-precision adder among N requesters.
// A round-robin arbiter picks one request per cycle. The winning operands go
// into an operand register (stage A) that drives the adder. The adder's sum is
// captured in a result register (stage B), which is handed off with the
// requester ID over a valid/ready handshake.

module fp_add_arbiter #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_s,
  output logic              res_valid,
  output logic [31:0]       res_sum,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic [CNTW-1:0]   op_count
);

  // Round-robin pointer: index where the next search begins.
  logic [IDW-1:0]  rrPtr_q, rrPtr_d;

  // Stage A: operand register feeding the external adder.
  logic            aValid_q, aValid_d;
  logic [IDW-1:0]  aId_q, aId_d;
  logic [31:0]     opA_q, opA_d;
  logic [31:0]     opB_q, opB_d;

  // Stage B: result register presented to the consumer.
  logic            bValid_q, bValid_d;
  logic [31:0]     sum_q, sum_d;
  logic [IDW-1:0]  resId_q, resId_d;

  // Completed hand-off counter.
  logic [CNTW-1:0] opCount_q, opCount_d;

  // Pipeline flow control and arbitration results.
  logic            bReady;
  logic            aReady;
  logic            found;
  logic [IDW-1:0]  grantIdx;
  logic [IDW:0]    cand;
  logic            accept;
  logic            handoff;

  // A stage can take new data when it is empty or its contents move on this cycle.
  always_comb begin
    bReady  = !bValid_q || res_ready;
    aReady  = !aValid_q || bReady;
    handoff = bValid_q && res_ready;
  end

  // Search req_valid from rrPtr_q upward, wrapping at N; the first hit wins.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rrPtr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found    = 1'b1;
        grantIdx = cand[IDW-1:0];
      end
    end
  end

  // Grant is one-hot and only issued when stage A can take the operands.
  always_comb begin
    req_ready = '0;
    accept    = found && aReady;
    if (accept) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  // Stage A next state: load the winner, drain when empty-able, else hold.
  always_comb begin
    aValid_d = aValid_q;
    aId_d    = aId_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    rrPtr_d  = rrPtr_q;
    if (accept) begin
      aValid_d = 1'b1;
      aId_d    = grantIdx;
      opA_d    = req_a[32*grantIdx +: 32];
      opB_d    = req_b[32*grantIdx +: 32];
      rrPtr_d  = (grantIdx == IDW'(N-1)) ? '0 : grantIdx + 1'b1;
    end else if (aReady) begin
      aValid_d = 1'b0;
    end
  end

  // Stage B next state: capture the adder sum, or empty once the consumer takes it.
  always_comb begin
    bValid_d = bValid_q;
    sum_d    = sum_q;
    resId_d  = resId_q;
    if (aValid_q && bReady) begin
      bValid_d = 1'b1;
      sum_d    = add_s;
      resId_d  = aId_q;
    end else if (res_ready) begin
      bValid_d = 1'b0;
    end
  end

  // Count every accepted result; wraps naturally at the counter width.
  always_comb begin
    opCount_d = opCount_q;
    if (handoff) begin
      opCount_d = opCount_q + 1'b1;
    end
  end

  // Arbiter pointer and stage A registers; reset discards any in-flight operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q  <= '0;
      aValid_q <= 1'b0;
      aId_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
    end else begin
      rrPtr_q  <= rrPtr_d;
      aValid_q <= aValid_d;
      aId_q    <= aId_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
    end
  end

  // Stage B registers and hand-off counter; reset drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bValid_q  <= 1'b0;
      sum_q     <= '0;
      resId_q   <= '0;
      opCount_q <= '0;
    end else begin
      bValid_q  <= bValid_d;
      sum_q     <= sum_d;
      resId_q   <= resId_d;
      opCount_q <= opCount_d;
    end
  end

  assign add_a     = opA_q;
  assign add_b     = opB_q;
  assign res_valid = bValid_q;
  assign res_sum   = sum_q;
  assign res_id    = resId_q;
  assign op_count  = opCount_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter
// Directed bench for fp_add_arbiter with a table-driven stand-in for the
// external single-precision adder covering the operand pairs used here.

module tb_fp_add_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk;
  logic              rst;
  logic [N-1:0]      reqValid;
  logic [32*N-1:0]   reqA;
  logic [32*N-1:0]   reqB;
  logic [N-1:0]      reqReady;
  logic [31:0]       addA;
  logic [31:0]       addB;
  logic [31:0]       addS;
  logic              resValid;
  logic [31:0]       resSum;
  logic [IDW-1:0]    resId;
  logic              resReady;
  logic [CNTW-1:0]   opCount;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Operand table per requester and the hand-computed IEEE-754 sums.
  logic [31:0] tblA   [N] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40800000};
  logic [31:0] tblB   [N] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000};
  logic [31:0] tblSum [N] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h41000000};

  fp_add_arbiter #(.N(N), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_ready (reqReady),
    .add_a     (addA),
    .add_b     (addB),
    .add_s     (addS),
    .res_valid (resValid),
    .res_sum   (resSum),
    .res_id    (resId),
    .res_ready (resReady),
    .op_count  (opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: exact sums for the directed operand pairs, scrambled otherwise.
  always_comb begin
    case ({addA, addB})
      {32'h3F800000, 32'h3F800000}: addS = 32'h40000000;
      {32'h3F800000, 32'h40000000}: addS = 32'h40400000;
      {32'h40000000, 32'h40000000}: addS = 32'h40800000;
      {32'h40800000, 32'h40800000}: addS = 32'h41000000;
      {32'h3F800000, 32'hBF800000}: addS = 32'h00000000;
      default:                      addS = addA ^ addB ^ 32'hA5A5A5A5;
    endcase
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready);
    reqValid = valid;
    resReady = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    resReady = 1'b0;
    reqA     = '0;
    reqB     = '0;
    #2;
    checkOutput("rst_res_valid", resValid, 0);
    checkOutput("rst_add_a", addA, 0);
    checkOutput("rst_add_b", addB, 0);
    checkOutput("rst_res_sum", resSum, 0);
    checkOutput("rst_res_id", resId, 0);
    checkOutput("rst_op_count", opCount, 0);
    checkOutput("rst_req_ready", reqReady, 0);
    waitCycle();
    waitCycle();
    rst = 1'b0;
    waitCycle();

    // Single op: 1.0 + 2.0 from requester 0.
    reqA[31:0] = 32'h3F800000;
    reqB[31:0] = 32'h40000000;
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_grant", reqReady, 4'b0001);
    waitCycle();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_add_a", addA, 32'h3F800000);
    checkOutput("single_add_b", addB, 32'h40000000);
    checkOutput("single_not_yet", resValid, 0);
    waitCycle();
    checkOutput("single_valid", resValid, 1);
    checkOutput("single_sum", resSum, 32'h40400000);
    checkOutput("single_id", resId, 0);
    waitCycle();
    checkOutput("single_drained", resValid, 0);
    checkOutput("single_count", opCount, 1);

    // Restart so arbitration begins at index 0 and the counter is clear.
    rst = 1'b1;
    #1;
    checkOutput("rst2_op_count", opCount, 0);
    rst = 1'b0;

    // Round-robin with all four requesters continuously valid.
    for (int i = 0; i < N; i++) begin
      reqA[32*i +: 32] = tblA[i];
      reqB[32*i +: 32] = tblB[i];
    end
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), reqReady, 4'b0001 << (i % N));
      if (i >= 2) begin
        checkOutput($sformatf("rr_valid%0d", i), resValid, 1);
        checkOutput($sformatf("rr_id%0d", i), resId, (i - 2) % N);
        checkOutput($sformatf("rr_sum%0d", i), resSum, tblSum[(i - 2) % N]);
      end
      waitCycle();
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rr_count_mid", opCount, 6);
    checkOutput("rr_id6", resId, 2);
    checkOutput("rr_sum6", resSum, tblSum[2]);
    waitCycle();
    checkOutput("rr_id7", resId, 3);
    checkOutput("rr_sum7", resSum, tblSum[3]);
    waitCycle();
    checkOutput("rr_drained", resValid, 0);
    checkOutput("rr_count", opCount, 8);

    // Back-pressure: consumer stalls with requesters 0 and 2 valid.
    applyStimulus(4'b0101, 1'b0);
    checkOutput("bp_grant0", reqReady, 4'b0001);
    waitCycle();
    checkOutput("bp_grant2", reqReady, 4'b0100);
    waitCycle();
    for (int h = 0; h < 2; h++) begin
      checkOutput($sformatf("bp_blocked%0d", h), reqReady, 4'b0000);
      checkOutput($sformatf("bp_bvalid%0d", h), resValid, 1);
      checkOutput($sformatf("bp_bsum%0d", h), resSum, 32'h40000000);
      checkOutput($sformatf("bp_bid%0d", h), resId, 0);
      checkOutput($sformatf("bp_add_a%0d", h), addA, 32'h3F800000);
      checkOutput($sformatf("bp_add_b%0d", h), addB, 32'h40000000);
      waitCycle();
    end
    applyStimulus(4'b0101, 1'b1);
    checkOutput("bp_regrant0", reqReady, 4'b0001);
    waitCycle();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("bp_sum2", resSum, 32'h40400000);
    checkOutput("bp_id2", resId, 2);
    waitCycle();
    checkOutput("bp_sum0", resSum, 32'h40000000);
    checkOutput("bp_id0", resId, 0);
    waitCycle();
    checkOutput("bp_drained", resValid, 0);
    checkOutput("bp_count", opCount, 11);

    // Cancellation on requester 1, then wrap from pointer 2 to requester 3.
    reqA[63:32] = 32'h3F800000;
    reqB[63:32] = 32'hBF800000;
    applyStimulus(4'b0010, 1'b1);
    checkOutput("cx_grant1", reqReady, 4'b0010);
    waitCycle();
    applyStimulus(4'b0000, 1'b1);
    waitCycle();
    checkOutput("cx_valid", resValid, 1);
    checkOutput("cx_sum", resSum, 32'h00000000);
    checkOutput("cx_id", resId, 1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_grant3", reqReady, 4'b1000);
    waitCycle();
    checkOutput("wrap_grant0", reqReady, 4'b0001);
    waitCycle();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_id3", resId, 3);
    checkOutput("wrap_sum3", resSum, 32'h41000000);
    waitCycle();
    checkOutput("wrap_id0", resId, 0);
    checkOutput("wrap_sum0", resSum, 32'h40000000);
    waitCycle();
    checkOutput("wrap_count", opCount, 14);

    // Reset while both stages are occupied.
    applyStimulus(4'b0001, 1'b0);
    waitCycle();
    waitCycle();
    checkOutput("mid_bvalid", resValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", resValid, 0);
    checkOutput("mid_rst_count", opCount, 0);
    checkOutput("mid_rst_add_a", addA, 0);
    checkOutput("mid_rst_sum", resSum, 0);
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    for (int s = 0; s < 3; s++) begin
      waitCycle();
      checkOutput($sformatf("mid_no_stale%0d", s), resValid, 0);
    end
    applyStimulus(4'b1010, 1'b1);
    checkOutput("mid_first_grant", reqReady, 4'b0010);
    waitCycle();
    applyStimulus(4'b0000, 1'b1);
    waitCycle();
    checkOutput("mid_new_valid", resValid, 1);
    checkOutput("mid_new_id", resId, 1);
    checkOutput("mid_new_sum", resSum, 32'h00000000);
    waitCycle();
    checkOutput("mid_new_count", opCount, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
